// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings and FSM state type.
// Optional feature macro used by alu_seq: ALU_SAT_EN (ADD/SUB saturation).
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;
    localparam logic [3:0] ALU_MUL  = 4'd11;

    // Highest legal opcode; anything above is reported through flag_ill.
    localparam logic [3:0] ALU_OP_LAST = ALU_MUL;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle for alu_seq.
// master: operation source and result consumer; slave: the ALU.
interface alu_seq_if #(
    parameter int WORD_SIZE    = 32,
    parameter int ALU_CON_SIZE = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [ALU_CON_SIZE-1:0] alu_con;
    logic [WORD_SIZE-1:0]    data_in_1;
    logic [WORD_SIZE-1:0]    data_in_2;
    logic                    out_valid;
    logic                    out_ready;
    logic [WORD_SIZE-1:0]    data_out;
    logic                    flag_zero;
    logic                    flag_ovf;
    logic                    flag_ill;
    logic                    busy;

    modport master (
        output in_valid, alu_con, data_in_1, data_in_2, out_ready,
        input  in_ready, out_valid, data_out, flag_zero, flag_ovf, flag_ill, busy
    );

    modport slave (
        input  in_valid, alu_con, data_in_1, data_in_2, out_ready,
        output in_ready, out_valid, data_out, flag_zero, flag_ovf, flag_ill, busy
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, LSB first, keeping the low WORD_SIZE product bits.
// done is asserted during the last step; product then carries the final sum
// so the caller can register it on that same edge.
module alu_mul_iter #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic                 done,
    output logic [WORD_SIZE-1:0] product
);
    localparam int CW = $clog2(WORD_SIZE);
    localparam logic [CW-1:0] CNT_LAST = CW'(WORD_SIZE - 1);

    logic                 running;
    logic [CW-1:0]        cnt;
    logic [WORD_SIZE-1:0] acc;
    logic [WORD_SIZE-1:0] mcand;
    logic [WORD_SIZE-1:0] mplier;
    logic [WORD_SIZE-1:0] step_sum;

    assign step_sum = mplier[0] ? (acc + mcand) : acc;
    assign done     = running && (cnt == CNT_LAST);
    assign product  = step_sum;

    // Load operands on start, then one shift-add step per cycle for WORD_SIZE cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= a;
            mplier  <= b;
        end else if (running) begin
            acc    <= step_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt == CNT_LAST) begin
                running <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle ops finish in one cycle, MUL iterates.
// Optional macro ALU_SAT_EN: ADD/SUB saturate on signed overflow instead of wrapping.
//
//  state   | meaning
//  IDLE    | ready for a new operation, no result pending
//  MUL     | iterative multiply in progress, input stalled
//  DONE    | result presented, held until out_ready
module alu_seq
    import alu_pkg::*;
#(
    parameter int WORD_SIZE    = 32,
    parameter int ALU_CON_SIZE = 4
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WORD_SIZE);
    localparam int MSB = WORD_SIZE - 1;

    state_t               state;
    logic [3:0]           op;
    logic                 op_hi;
    logic                 op_ill;
    logic                 op_mul;
    logic                 accept;
    logic [WORD_SIZE-1:0] a;
    logic [WORD_SIZE-1:0] b;
    logic [WORD_SIZE-1:0] sum;
    logic [WORD_SIZE-1:0] diff;
    logic [WORD_SIZE-1:0] res;
    logic                 ovf;
    logic [SHW-1:0]       shamt;
    logic                 mul_done;
    logic [WORD_SIZE-1:0] mul_res;

    logic [WORD_SIZE-1:0] data_out_q;
    logic                 zero_q;
    logic                 ovf_q;
    logic                 ill_q;
    logic                 out_valid_q;

    assign a     = bus.data_in_1;
    assign b     = bus.data_in_2;
    assign op    = bus.alu_con[3:0];
    assign shamt = b[SHW-1:0];
    assign sum   = a + b;
    assign diff  = a - b;

    generate
        if (ALU_CON_SIZE > 4) begin : g_op_hi
            assign op_hi = |bus.alu_con[ALU_CON_SIZE-1:4];
        end else begin : g_no_op_hi
            assign op_hi = 1'b0;
        end
    endgenerate

    assign op_ill = op_hi || (op > ALU_OP_LAST);
    assign op_mul = !op_hi && (op == ALU_MUL);

    assign bus.in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.flag_zero = zero_q;
    assign bus.flag_ovf  = ovf_q;
    assign bus.flag_ill  = ill_q;

    assign accept = bus.in_valid && bus.in_ready;

    alu_mul_iter #(.WORD_SIZE(WORD_SIZE)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && op_mul),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_res)
    );

    // Single-cycle result mux with overflow detection and optional saturation.
    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (op)
            ALU_ADD: begin
                res = sum;
                ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                res = diff;
                ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_XOR:  res = a ^ b;
            ALU_NOR:  res = ~(a | b);
            ALU_SLL:  res = a << shamt;
            ALU_SRL:  res = a >> shamt;
            ALU_SRA:  res = $signed(a) >>> shamt;
            ALU_SLT:  res = {{(WORD_SIZE-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: res = {{(WORD_SIZE-1){1'b0}}, (a < b)};
            default:  res = '0;
        endcase
        if (op_hi) begin
            res = '0;
            ovf = 1'b0;
        end
`ifdef ALU_SAT_EN
        // The true result's sign follows A whenever ADD/SUB overflows.
        if (ovf) begin
            res = a[MSB] ? {1'b1, {(WORD_SIZE-1){1'b0}}} : {1'b0, {(WORD_SIZE-1){1'b1}}};
        end
`endif
    end

    // Control FSM with registered result and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            data_out_q  <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (op_mul) begin
                            state <= ST_MUL;
                        end else begin
                            data_out_q  <= res;
                            zero_q      <= (res == '0);
                            ovf_q       <= ovf;
                            ill_q       <= op_ill;
                            out_valid_q <= 1'b1;
                            state       <= ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        data_out_q  <= mul_res;
                        zero_q      <= (mul_res == '0);
                        ovf_q       <= 1'b0;
                        ill_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        if (bus.in_valid) begin
                            if (op_mul) begin
                                out_valid_q <= 1'b0;
                                state       <= ST_MUL;
                            end else begin
                                data_out_q <= res;
                                zero_q     <= (res == '0);
                                ovf_q      <= ovf;
                                ill_q      <= op_ill;
                            end
                        end else begin
                            out_valid_q <= 1'b0;
                            state       <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with hand-computed expected results.
module tb_alu_seq;
    import alu_pkg::*;

`ifdef ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    alu_seq_if #(.WORD_SIZE(32), .ALU_CON_SIZE(4)) bus ();

    alu_seq #(.WORD_SIZE(32), .ALU_CON_SIZE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one op with out_ready=1, wait for its result and check it.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] r,
                          input logic z, input logic o, input logic i);
        int n;
        bus.alu_con   = op;
        bus.data_in_1 = a;
        bus.data_in_2 = b;
        bus.in_valid  = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_data"}, bus.data_out, r);
        chk({tag, "_zero"}, 32'(bus.flag_zero), 32'(z));
        chk({tag, "_ovf"}, 32'(bus.flag_ovf), 32'(o));
        chk({tag, "_ill"}, 32'(bus.flag_ill), 32'(i));
        @(negedge clk);
    endtask

    initial begin
        int n;
        int bad;
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.alu_con   = '0;
        bus.data_in_1 = '0;
        bus.data_in_2 = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_data", bus.data_out, 32'd0);
        chk("rst_flags", {29'd0, bus.flag_zero, bus.flag_ovf, bus.flag_ill}, 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Single-op vectors
        run_op("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h1, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_op("sub_ovf", ALU_SUB, 32'h8000_0000, 32'h1, SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        run_op("add_wrap0", ALU_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1'b0);
        run_op("and", ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0);
        run_op("nor", ALU_NOR, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_op("sll_mask", ALU_SLL, 32'h1, 32'h21, 32'h2, 1'b0, 1'b0, 1'b0);
        run_op("srl", ALU_SRL, 32'h8000_0000, 32'h4, 32'h0800_0000, 1'b0, 1'b0, 1'b0);
        run_op("slt0", ALU_SLT, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0);
        run_op("sltu0", ALU_SLTU, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        run_op("sltu1", ALU_SLTU, 32'h0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        run_op("mul_big", ALU_MUL, 32'h0001_0000, 32'h0001_0001, 32'h0000_0000 + 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        run_op("ill12", 4'd12, 32'h5, 32'h6, 32'h0, 1'b1, 1'b0, 1'b1);

        // MUL -3 * 7: stalled for 32 cycles, then 0xFFFFFFEB
        bus.alu_con   = ALU_MUL;
        bus.data_in_1 = 32'hFFFF_FFFD;
        bus.data_in_2 = 32'd7;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        bad = 0;
        while (!bus.out_valid && n < 100) begin
            if (bus.in_ready) bad++;
            @(negedge clk);
            n++;
        end
        chk("mul_latency", 32'(n), 32'd32);
        chk("mul_in_ready_low", 32'(bad), 32'd0);
        chk("mul_data", bus.data_out, 32'hFFFF_FFEB);
        chk("mul_zero", 32'(bus.flag_zero), 32'd0);
        @(negedge clk);

        // SUB 5-5 held with out_ready=0 for 5 cycles
        bus.out_ready = 1'b0;
        bus.alu_con   = ALU_SUB;
        bus.data_in_1 = 32'd5;
        bus.data_in_2 = 32'd5;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bad = 0;
        repeat (5) begin
            if (!bus.out_valid || bus.data_out != 32'd0 || !bus.flag_zero || bus.in_ready) bad++;
            @(negedge clk);
        end
        chk("hold_stable", 32'(bad), 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("hold_release", 32'(bus.out_valid), 32'd0);

        // Back-to-back XOR, SRA, SLT
        bus.alu_con   = ALU_XOR;
        bus.data_in_1 = 32'h0F0F_0F0F;
        bus.data_in_2 = 32'hFF00_FF00;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        chk("b2b_xor", bus.data_out, 32'hF00F_F00F);
        chk("b2b_xor_valid", 32'(bus.out_valid), 32'd1);
        bus.alu_con   = ALU_SRA;
        bus.data_in_1 = 32'h8000_0000;
        bus.data_in_2 = 32'd4;
        @(negedge clk);
        chk("b2b_sra", bus.data_out, 32'hF800_0000);
        bus.alu_con   = ALU_SLT;
        bus.data_in_1 = 32'hFFFF_FFFF;
        bus.data_in_2 = 32'd0;
        @(negedge clk);
        chk("b2b_slt", bus.data_out, 32'd1);
        chk("b2b_slt_valid", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_end_valid", 32'(bus.out_valid), 32'd0);

        // Reset during MUL discards it
        bus.alu_con   = ALU_MUL;
        bus.data_in_1 = 32'd5;
        bus.data_in_2 = 32'd6;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mul_busy", 32'(bus.busy), 32'd0);
        chk("rst_mul_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy) bad++;
        end
        chk("rst_mul_no_stray", 32'(bad), 32'd0);
        run_op("add_after_rst", ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);

        // Illegal opcode then a legal op clears flag_ill
        bus.alu_con   = 4'd13;
        bus.data_in_1 = 32'h1234;
        bus.data_in_2 = 32'h1;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        chk("ill13_flag", 32'(bus.flag_ill), 32'd1);
        chk("ill13_data", bus.data_out, 32'd0);
        bus.alu_con   = ALU_OR;
        bus.data_in_1 = 32'd1;
        bus.data_in_2 = 32'd2;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("ill_clear_flag", 32'(bus.flag_ill), 32'd0);
        chk("ill_clear_data", bus.data_out, 32'd3);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
